// File: rtl/array_word_assembler.sv
// Assembles a valid/ready stream of WIDTH-bit words into an unpacked array of DEPTH elements.
// Optional shadow buffer for back-to-back arrays: define ARRAY_WORD_ASSEMBLER_SKID_EN.
module array_word_assembler #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data [DEPTH-1:0],
  output logic [CW-1:0]    out_count,
  output logic             out_split
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] elem [DEPTH-1:0];
  logic             is_last_slot;

  assign is_last_slot = (idx == IW'(DEPTH - 1));
  assign out_valid    = (state == HOLD);
  assign out_data     = elem;

`ifdef ARRAY_WORD_ASSEMBLER_SKID_EN
  logic [WIDTH-1:0] sh     [DEPTH-1:0];
  logic [WIDTH-1:0] sh_n   [DEPTH-1:0];
  logic [IW-1:0]    sh_idx, sh_idx_n;
  logic [CW-1:0]    sh_count, sh_count_n;
  logic             sh_split, sh_split_n;
  logic             sh_done, sh_done_n;

  assign in_ready = (state == FILL) || !sh_done;

  // Next shadow contents including this cycle's accept, so a handshake in the
  // same cycle promotes or moves the word that just arrived.
  always_comb begin
    sh_n       = sh;
    sh_idx_n   = sh_idx;
    sh_count_n = sh_count;
    sh_split_n = sh_split;
    sh_done_n  = sh_done;
    if (state == HOLD && in_valid && in_ready) begin
      sh_n[sh_idx] = in_data;
      if (in_last || sh_idx == IW'(DEPTH - 1)) begin
        sh_done_n  = 1'b1;
        sh_count_n = CW'(sh_idx) + CW'(1);
        sh_split_n = (sh_idx == IW'(DEPTH - 1)) && !in_last;
        sh_idx_n   = '0;
      end else begin
        sh_idx_n = sh_idx + IW'(1);
      end
    end
  end
`else
  assign in_ready = (state == FILL);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      idx       <= '0;
      elem      <= '{default: '0};
      out_count <= '0;
      out_split <= 1'b0;
`ifdef ARRAY_WORD_ASSEMBLER_SKID_EN
      sh        <= '{default: '0};
      sh_idx    <= '0;
      sh_count  <= '0;
      sh_split  <= 1'b0;
      sh_done   <= 1'b0;
`endif
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            elem[idx] <= in_data;
            if (in_last || is_last_slot) begin
              state     <= HOLD;
              out_count <= CW'(idx) + CW'(1);
              out_split <= is_last_slot && !in_last;
              idx       <= '0;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        HOLD: begin
`ifdef ARRAY_WORD_ASSEMBLER_SKID_EN
          if (out_ready) begin
            // A cleared shadow is all zero, so copying it also clears the primary.
            elem <= sh_n;
            if (sh_done_n) begin
              out_count <= sh_count_n;
              out_split <= sh_split_n;
            end else begin
              state     <= FILL;
              idx       <= sh_idx_n;
              out_count <= '0;
              out_split <= 1'b0;
            end
            sh       <= '{default: '0};
            sh_idx   <= '0;
            sh_count <= '0;
            sh_split <= 1'b0;
            sh_done  <= 1'b0;
          end else begin
            sh       <= sh_n;
            sh_idx   <= sh_idx_n;
            sh_count <= sh_count_n;
            sh_split <= sh_split_n;
            sh_done  <= sh_done_n;
          end
`else
          if (out_ready) begin
            state     <= FILL;
            elem      <= '{default: '0};
            out_count <= '0;
            out_split <= 1'b0;
          end
`endif
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_array_word_assembler.sv
// Directed self-checking bench for array_word_assembler (WIDTH=8, DEPTH=4).
module tb_array_word_assembler;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data [3:0];
  logic [2:0] out_count;
  logic       out_split;

  int vectors = 0;
  int errors  = 0;

  array_word_assembler #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_split (out_split)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one word for one cycle; callers only use it while the block is in FILL.
  task automatic send(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++;
    if (out_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", out_count); end
    vectors++;
    if (out_split !== 1'b0) begin errors++; $display("FAIL reset_split got %b want 0", out_split); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_data[i] !== 8'h00) begin errors++; $display("FAIL reset_elem%0d got %h want 00", i, out_data[i]); end
    end
  endtask

  task automatic test_full_frame();
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid word%0d got %b want 0", i, out_valid); end
      send(exp[i], i == 3);
    end
    vectors++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL full_out_valid got %b want 1", out_valid); end
    vectors++;
    if (out_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", out_count); end
    vectors++;
    if (out_split !== 1'b0) begin errors++; $display("FAIL full_split got %b want 0", out_split); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_data[i] !== exp[i]) begin errors++; $display("FAIL full_elem%0d got %h want %h", i, out_data[i], exp[i]); end
    end
    tick();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL full_after_hs in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    vectors++;
    if (out_data[0] !== 8'h00 || out_count !== 3'd0) begin
      errors++; $display("FAIL full_cleared elem0=%h count=%0d want 00/0", out_data[0], out_count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_short_frame();
    logic [7:0] exp [4] = '{8'hA5, 8'h5A, 8'h00, 8'h00};
    out_ready = 1'b1;
    send(8'hA5, 1'b0);
    tick(); tick();
    vectors++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL short_gap_valid got %b want 0", out_valid); end
    out_ready = 1'b0;
    send(8'h5A, 1'b1);
    vectors++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL short_out_valid got %b want 1", out_valid); end
    vectors++;
    if (out_count !== 3'd2) begin errors++; $display("FAIL short_count got %0d want 2", out_count); end
    vectors++;
    if (out_split !== 1'b0) begin errors++; $display("FAIL short_split got %b want 0", out_split); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_data[i] !== exp[i]) begin errors++; $display("FAIL short_elem%0d got %h want %h", i, out_data[i], exp[i]); end
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    send(8'h7E, 1'b1);
    vectors++;
    if (out_count !== 3'd1 || out_data[0] !== 8'h7E || out_data[1] !== 8'h00) begin
      errors++; $display("FAIL single_word count=%0d e0=%h e1=%h want 1/7e/00", out_count, out_data[0], out_data[1]);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_split();
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_count !== 3'd4 || out_split !== 1'b1) begin
      errors++; $display("FAIL split_first valid=%b count=%0d split=%b want 1/4/1", out_valid, out_count, out_split);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_data[i] !== 8'(i + 1)) begin errors++; $display("FAIL split_first_elem%0d got %h want %h", i, out_data[i], 8'(i + 1)); end
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    send(8'h05, 1'b0);
    send(8'h06, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_count !== 3'd2 || out_split !== 1'b0) begin
      errors++; $display("FAIL split_second valid=%b count=%0d split=%b want 1/2/0", out_valid, out_count, out_split);
    end
    vectors++;
    if (out_data[0] !== 8'h05 || out_data[1] !== 8'h06 || out_data[2] !== 8'h00 || out_data[3] !== 8'h00) begin
      errors++; $display("FAIL split_second_data got %h %h %h %h want 05 06 00 00",
                         out_data[0], out_data[1], out_data[2], out_data[3]);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic exp_rdy;
    for (int i = 0; i < 4; i++) send(8'h80 + 8'(i), i == 3);
    in_valid = 1'b1; in_data = 8'h90; in_last = 1'b1;
    for (int k = 0; k < 10; k++) begin
`ifdef ARRAY_WORD_ASSEMBLER_SKID_EN
      exp_rdy = (k == 0);
`else
      exp_rdy = 1'b0;
`endif
      vectors++;
      if (in_ready !== exp_rdy || out_valid !== 1'b1 || out_data[0] !== 8'h80 || out_data[3] !== 8'h83) begin
        errors++; $display("FAIL bp_hold cyc%0d in_ready=%b valid=%b e0=%h e3=%h want %b/1/80/83",
                           k, in_ready, out_valid, out_data[0], out_data[3], exp_rdy);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
`ifdef ARRAY_WORD_ASSEMBLER_SKID_EN
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0;
`else
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
`endif
    vectors++;
    if (out_valid !== 1'b1 || out_count !== 3'd1 || out_data[0] !== 8'h90 || out_data[1] !== 8'h00) begin
      errors++; $display("FAIL bp_next valid=%b count=%0d e0=%h e1=%h want 1/1/90/00",
                         out_valid, out_count, out_data[0], out_data[1]);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup valid=%b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_frame();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || out_count !== 3'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_ctrl valid=%b count=%0d in_ready=%b want 0/0/1", out_valid, out_count, in_ready);
    end
    vectors++;
    if (out_data[0] !== 8'h00 || out_data[1] !== 8'h00) begin
      errors++; $display("FAIL rstmid_zero e0=%h e1=%h want 00/00", out_data[0], out_data[1]);
    end
    for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), i == 3);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_data[i] !== 8'hC0 + 8'(i)) begin
        errors++; $display("FAIL rstmid_elem%0d got %h want %h", i, out_data[i], 8'hC0 + 8'(i));
      end
    end
    vectors++;
    if (out_count !== 3'd4 || out_split !== 1'b0) begin
      errors++; $display("FAIL rstmid_count count=%0d split=%b want 4/0", out_count, out_split);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int sent = 0, arrays = 0, stalls = 0, cyc = 0, exp_stalls;
    logic acc;
    out_ready = 1'b1;
    while ((sent < 12 || arrays < 3) && cyc < 60) begin
      in_valid = (sent < 12);
      in_data  = 8'(sent);
      in_last  = (sent % 4 == 3);
      if (out_valid) begin
        for (int j = 0; j < 4; j++) begin
          vectors++;
          if (out_data[j] !== 8'(arrays * 4 + j)) begin
            errors++; $display("FAIL b2b_arr%0d_elem%0d got %h want %h", arrays, j, out_data[j], 8'(arrays * 4 + j));
          end
        end
        vectors++;
        if (out_count !== 3'd4) begin errors++; $display("FAIL b2b_arr%0d_count got %0d want 4", arrays, out_count); end
        arrays++;
      end
      acc = in_valid && in_ready;
      if (in_valid && !in_ready) stalls++;
      tick();
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
`ifdef ARRAY_WORD_ASSEMBLER_SKID_EN
    exp_stalls = 0;
`else
    exp_stalls = 2;
`endif
    vectors++;
    if (arrays != 3 || sent != 12) begin
      errors++; $display("FAIL b2b_timeout arrays=%0d words=%0d want 3/12", arrays, sent);
    end
    vectors++;
    if (stalls != exp_stalls) begin errors++; $display("FAIL b2b_stalls got %0d want %0d", stalls, exp_stalls); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_split();
    test_backpressure();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
